ifu_fetch_unit: RTL and testbench

//   Instruction fetch unit for the RV32E multicycle core. It is the producer end of the decoder's instruction

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_fetch_unit.sv | 125 ++++++++++++
 tb/tb_ifu_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: fetch FSM state encoding, fixed AXI read attributes and the NOP
//          word substituted for faulting fetches.
// Ports:   none (package).
package ifu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_OUT  = 2'd3
   } ifu_state_e;

   localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam logic [31:0] INS_NOP        = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch_unit.sv
// rtl/ifu_fetch_unit.sv - single-outstanding AXI4 instruction fetch unit
//
// Purpose: issues one single-beat AXI4 read per instruction, holds the fetched
//          word until the decoder accepts it, and applies pc redirects.
// Ports:
//   clock, reset                     core clock, synchronous active-high reset
//   i_redirect_valid/i_redirect_pc   one-cycle redirect pulse and target
//   o_arvalid/i_arready/o_araddr     AXI read-address channel
//   o_arlen/o_arsize/o_arburst       constant single-beat word read
//   i_rvalid/o_rready/i_rdata        AXI read-data channel
//   i_rresp/i_rlast                  read response (rlast unused)
//   o_ins_valid/i_ins_ready          instruction handshake to the decoder
//   o_ins/o_pc/o_fault               instruction word, its pc, fetch fault
module ifu_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_arvalid,
   input  logic              i_arready,
   output logic [ADDR_W-1:0] o_araddr,
   output logic [7:0]        o_arlen,
   output logic [2:0]        o_arsize,
   output logic [1:0]        o_arburst,
   input  logic              i_rvalid,
   output logic              o_rready,
   input  logic [31:0]       i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rlast,
   output logic              o_ins_valid,
   input  logic              i_ins_ready,
   output logic [31:0]       o_ins,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_fault
);

   ifu_state_e        state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pend_pc;
   logic              kill;
   logic              fault_nxt;
   logic              unused_rlast;

   assign unused_rlast = i_rlast;
   assign fault_nxt    = (i_rresp != AXI_RESP_OKAY) || (pc[1:0] != 2'b00);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_ADDR;
         S_ADDR: if (i_arready) state_nxt = S_DATA;
         S_DATA: if (i_rvalid)
                    state_nxt = (kill || i_redirect_valid) ? S_ADDR : S_OUT;
         S_OUT:  if (i_redirect_valid || i_ins_ready) state_nxt = S_ADDR;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_arvalid   = (state == S_ADDR);
      o_rready    = (state == S_DATA);
      o_ins_valid = (state == S_OUT);
      o_araddr    = {pc[ADDR_W-1:2], 2'b00};
      o_arlen     = 8'd0;
      o_arsize    = AXI_SIZE_WORD;
      o_arburst   = AXI_BURST_INCR;
   end

   // pc / kill / instruction registers. While a read is in flight a redirect
   // cannot cancel it on the bus, so it is parked in pend_pc and the returning
   // beat is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= RESET_PC;
         pend_pc <= RESET_PC;
         kill    <= 1'b0;
         o_ins   <= 32'd0;
         o_pc    <= RESET_PC;
         o_fault <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (i_redirect_valid) pc <= i_redirect_pc;
            S_ADDR: if (i_redirect_valid) begin
                       kill    <= 1'b1;
                       pend_pc <= i_redirect_pc;
                    end
            S_DATA: begin
               if (i_rvalid) begin
                  // A redirect arriving with the beat is newer than any parked one.
                  if (i_redirect_valid) begin
                     pc   <= i_redirect_pc;
                     kill <= 1'b0;
                  end else if (kill) begin
                     pc   <= pend_pc;
                     kill <= 1'b0;
                  end else begin
                     o_ins   <= fault_nxt ? INS_NOP : i_rdata;
                     o_pc    <= pc;
                     o_fault <= fault_nxt;
                  end
               end else if (i_redirect_valid) begin
                  kill    <= 1'b1;
                  pend_pc <= i_redirect_pc;
               end
            end
            S_OUT: begin
               if (i_redirect_valid) pc <= i_redirect_pc;
               else if (i_ins_ready) pc <= pc + ADDR_W'(4);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb/tb_ifu_fetch_unit.sv - self-checking bench for ifu_fetch_unit
module tb_ifu_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h3000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        i_redirect_valid = 1'b0;
   logic [31:0] i_redirect_pc = 32'd0;
   logic        o_arvalid;
   logic        i_arready = 1'b0;
   logic [31:0] o_araddr;
   logic [7:0]  o_arlen;
   logic [2:0]  o_arsize;
   logic [1:0]  o_arburst;
   logic        i_rvalid = 1'b0;
   logic        o_rready;
   logic [31:0] i_rdata = 32'd0;
   logic [1:0]  i_rresp = 2'b00;
   logic        i_rlast = 1'b0;
   logic        o_ins_valid;
   logic        i_ins_ready = 1'b0;
   logic [31:0] o_ins;
   logic [31:0] o_pc;
   logic        o_fault;

   ifu_fetch_unit dut (
      .clock(clock), .reset(reset),
      .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
      .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
      .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
      .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata),
      .i_rresp(i_rresp), .i_rlast(i_rlast),
      .o_ins_valid(o_ins_valid), .i_ins_ready(i_ins_ready),
      .o_ins(o_ins), .o_pc(o_pc), .o_fault(o_fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        fault;
   } exp_t;

   typedef struct {
      int          ar_dly;
      int          r_dly;
      int          rdy_dly;
      logic [1:0]  resp;
      bit          redir;
      logic [31:0] redir_pc;
      logic [31:0] exp_pc;
      logic        exp_fault;
   } vec_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          t_ar = 0;
   int          t_out = 0;
   logic [31:0] exp_pc;

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h3000_0000) return 32'h0010_0513;
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic push_exp(input logic [31:0] pc, input logic [1:0] resp);
      exp_t e;
      e.pc    = pc;
      e.fault = (resp != 2'b00) || (pc[1:0] != 2'b00);
      e.ins   = e.fault ? NOP : mem_word(align(pc));
      sb.push_back(e);
   endtask

   task automatic wait_ar();
      int n = 0;
      while (o_arvalid !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      t_ar = cyc;
      chk("arvalid_wait", 32'(o_arvalid), 32'd1);
   endtask

   task automatic addr_phase(input int ar_dly, input logic [31:0] exp_addr,
                             input int redir_at, input logic [31:0] redir_pc);
      wait_ar();
      chk("araddr", o_araddr, exp_addr);
      chk("arlen", 32'(o_arlen), 32'd0);
      chk("arsize_burst", 32'({o_arsize, o_arburst}), 32'({3'b010, 2'b01}));
      for (int k = 0; k < ar_dly; k++) begin
         if (k == redir_at) begin
            i_redirect_valid = 1'b1;
            i_redirect_pc    = redir_pc;
         end
         step();
         i_redirect_valid = 1'b0;
         chk("arvalid_hold", 32'(o_arvalid), 32'd1);
         chk("araddr_hold", o_araddr, exp_addr);
      end
      i_arready = 1'b1;
      step();
      i_arready = 1'b0;
      chk("rready_after_ar", 32'({o_rready, o_arvalid}), 32'b10);
   endtask

   // redir_at == r_dly places the redirect in the same cycle as rvalid.
   task automatic data_phase(input int r_dly, input logic [1:0] resp, input logic [31:0] data,
                             input int redir_at, input logic [31:0] redir_pc);
      for (int k = 0; k <= r_dly; k++) begin
         if (k == redir_at) begin
            i_redirect_valid = 1'b1;
            i_redirect_pc    = redir_pc;
         end
         if (k == r_dly) begin
            i_rvalid = 1'b1;
            i_rdata  = data;
            i_rresp  = resp;
            i_rlast  = 1'b1;
         end
         step();
         i_redirect_valid = 1'b0;
         i_rvalid = 1'b0;
         i_rresp  = 2'b00;
         i_rlast  = 1'b0;
         if (k < r_dly) chk("rready_hold", 32'({o_rready, o_ins_valid}), 32'b10);
      end
   endtask

   task automatic out_phase(input int rdy_dly, input bit redir, input logic [31:0] redir_pc);
      exp_t e;
      t_out = cyc;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty: output phase with no expected entry");
         return;
      end
      e = sb[0];
      chk("ins_valid", 32'(o_ins_valid), 32'd1);
      chk("ins", o_ins, e.ins);
      chk("pc", o_pc, e.pc);
      chk("fault", 32'(o_fault), 32'(e.fault));
      for (int k = 0; k < rdy_dly; k++) begin
         step();
         chk("stall_valid", 32'(o_ins_valid), 32'd1);
         chk("stall_ins", o_ins, e.ins);
         chk("stall_pc", o_pc, e.pc);
         chk("stall_fault", 32'(o_fault), 32'(e.fault));
      end
      i_ins_ready = 1'b1;
      if (redir) begin
         i_redirect_valid = 1'b1;
         i_redirect_pc    = redir_pc;
      end
      step();
      i_ins_ready = 1'b0;
      i_redirect_valid = 1'b0;
      void'(sb.pop_front());
      chk("ins_valid_drop", 32'(o_ins_valid), 32'd0);
      exp_pc = redir ? redir_pc : e.pc + 32'd4;
   endtask

   task automatic do_fetch(input logic [31:0] pc, input int ar_dly, input int r_dly, input int rdy_dly,
                           input logic [1:0] resp, input bit redir, input logic [31:0] redir_pc);
      push_exp(pc, resp);
      addr_phase(ar_dly, align(pc), -1, 32'd0);
      data_phase(r_dly, resp, mem_word(align(pc)), -1, 32'd0);
      out_phase(rdy_dly, redir, redir_pc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valids"}, 32'({o_arvalid, o_rready, o_ins_valid}), 32'd0);
      chk({tag, "_ins"}, o_ins, 32'd0);
      chk({tag, "_fault"}, 32'(o_fault), 32'd0);
      chk({tag, "_pc"}, o_pc, RST_PC);
      chk({tag, "_araddr"}, o_araddr, RST_PC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   t0;

      vecs[0] = '{0, 0, 0, 2'b00, 1'b0, 32'd0,         32'h3000_0000, 1'b0};
      vecs[1] = '{0, 0, 5, 2'b00, 1'b0, 32'd0,         32'h3000_0004, 1'b0};
      vecs[2] = '{0, 0, 0, 2'b10, 1'b0, 32'd0,         32'h3000_0008, 1'b1};
      vecs[3] = '{2, 3, 1, 2'b00, 1'b1, 32'h3000_0200, 32'h3000_000C, 1'b0};
      vecs[4] = '{0, 1, 0, 2'b00, 1'b0, 32'd0,         32'h3000_0200, 1'b0};
      vecs[5] = '{1, 0, 2, 2'b11, 1'b0, 32'd0,         32'h3000_0204, 1'b1};
      vecs[6] = '{3, 2, 0, 2'b00, 1'b0, 32'd0,         32'h3000_0208, 1'b0};

      reset = 1'b1;
      step();
      step();
      chk_reset_outputs("reset");
      reset = 1'b0;
      t0 = cyc;

      for (int i = 0; i < 7; i++) begin
         push_exp(vecs[i].exp_pc, vecs[i].resp);
         chk("vec_fault_expect", 32'(sb[sb.size()-1].fault), 32'(vecs[i].exp_fault));
         addr_phase(vecs[i].ar_dly, align(vecs[i].exp_pc), -1, 32'd0);
         data_phase(vecs[i].r_dly, vecs[i].resp, mem_word(align(vecs[i].exp_pc)), -1, 32'd0);
         out_phase(vecs[i].rdy_dly, vecs[i].redir, vecs[i].redir_pc);
         if (i == 0) begin
            chk("first_ar_latency", 32'(t_ar - t0), 32'd1);
            chk("first_ins_latency", 32'(t_out - t0), 32'd3);
         end
      end

      // Slow address accept with redirects in S_ADDR then S_DATA: last target wins.
      addr_phase(4, align(exp_pc), 1, 32'h3000_0180);
      data_phase(2, 2'b00, mem_word(align(exp_pc)), 0, 32'h3000_0100);
      chk("kill_no_valid", 32'(o_ins_valid), 32'd0);
      chk("kill_refetch_ar", 32'(o_arvalid), 32'd1);
      chk("kill_refetch_addr", o_araddr, 32'h3000_0100);
      do_fetch(32'h3000_0100, 0, 0, 0, 2'b00, 1'b0, 32'd0);

      // Redirect in the same cycle as rvalid.
      addr_phase(0, 32'h3000_0104, -1, 32'd0);
      data_phase(0, 2'b00, mem_word(32'h3000_0104), 0, 32'h3000_0300);
      chk("rv_redir_no_valid", 32'(o_ins_valid), 32'd0);
      chk("rv_redir_addr", o_araddr, 32'h3000_0300);

      // Redirect in S_OUT without handshake, to a misaligned target.
      push_exp(32'h3000_0300, 2'b00);
      addr_phase(0, 32'h3000_0300, -1, 32'd0);
      data_phase(0, 2'b00, mem_word(32'h3000_0300), -1, 32'd0);
      chk("out_redir_valid", 32'(o_ins_valid), 32'd1);
      chk("out_redir_ins", o_ins, mem_word(32'h3000_0300));
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h3000_0042;
      step();
      i_redirect_valid = 1'b0;
      void'(sb.pop_front());
      chk("out_redir_drop", 32'(o_ins_valid), 32'd0);

      do_fetch(32'h3000_0042, 0, 0, 0, 2'b00, 1'b1, 32'hFFFF_FFFC);
      do_fetch(32'hFFFF_FFFC, 0, 0, 0, 2'b00, 1'b0, 32'd0);
      wait_ar();
      chk("wrap_addr", o_araddr, 32'h0000_0000);

      // Reset while in S_DATA.
      addr_phase(0, 32'h0000_0000, -1, 32'd0);
      reset = 1'b1;
      step();
      chk_reset_outputs("midreset");
      reset = 1'b0;
      sb.delete();
      do_fetch(RST_PC, 0, 0, 0, 2'b00, 1'b0, 32'd0);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
